// File: rtl/openram_pkg.sv
// Shared sizes, FSM state encoding and requester IDs for the OpenRAM port arbiter.
package openram_pkg;

    localparam int ADDR_SIZE   = 8;
    localparam int DATA_SIZE   = 32;
    localparam int WMASK_SIZE  = 4;
    localparam int SELECT_SIZE = 4;
    localparam int MAX_CHIPS   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPT
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/openram_rr_arbiter.sv
// Two-way round-robin grant; the priority pointer moves only when a grant is issued.
module openram_rr_arbiter
    import openram_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic a_req,
    input  logic b_req,
    output logic a_grant,
    output logic b_grant,
    output logic grant_id
);

    logic favour_b;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        a_grant  = enable && a_req && (!b_req || !favour_b);
        b_grant  = enable && b_req && (!a_req || favour_b);
        grant_id = b_grant ? REQ_B : REQ_A;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            favour_b <= 1'b0;
        end else if (a_grant) begin
            favour_b <= 1'b1;
        end else if (b_grant) begin
            favour_b <= 1'b0;
        end
    end

endmodule

// File: rtl/openram_port_arbiter.sv
// Shares one OpenRAM port between two requesters: arbitrate, pulse csb, wait out the
// read latency, then return the selected chip's dout (or 0 for writes) to the owner.
module openram_port_arbiter
    import openram_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            global_csb,
    input  logic                            a_valid,
    output logic                            a_ready,
    input  logic [SELECT_SIZE-1:0]          a_sel,
    input  logic [ADDR_SIZE-1:0]            a_addr,
    input  logic [DATA_SIZE-1:0]            a_din,
    input  logic                            a_web,
    input  logic [WMASK_SIZE-1:0]           a_wmask,
    output logic                            a_rsp_valid,
    output logic [DATA_SIZE-1:0]            a_rsp_data,
    input  logic                            b_valid,
    output logic                            b_ready,
    input  logic [SELECT_SIZE-1:0]          b_sel,
    input  logic [ADDR_SIZE-1:0]            b_addr,
    input  logic [DATA_SIZE-1:0]            b_din,
    input  logic                            b_web,
    input  logic [WMASK_SIZE-1:0]           b_wmask,
    output logic                            b_rsp_valid,
    output logic [DATA_SIZE-1:0]            b_rsp_data,
    output logic [ADDR_SIZE-1:0]            sram_addr,
    output logic [DATA_SIZE-1:0]            sram_din,
    output logic                            sram_web,
    output logic [WMASK_SIZE-1:0]           sram_wmask,
    output logic [MAX_CHIPS-1:0]            sram_csb,
    input  logic [MAX_CHIPS*DATA_SIZE-1:0]  sram_dout
);

    localparam logic [7:0] WAIT_LAST = 8'(READ_LATENCY - 2);

    state_t                  state, state_nxt;
    logic [SELECT_SIZE-1:0]  lat_sel;
    logic                    owner;
    logic [7:0]              wait_cnt;
    logic                    enable, a_grant, b_grant, grant_id, accept;
    logic                    sel_in_range;
    logic [DATA_SIZE-1:0]    rd_word;

    openram_rr_arbiter u_rr (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .a_req    (a_valid),
        .b_req    (b_valid),
        .a_grant  (a_grant),
        .b_grant  (b_grant),
        .grant_id (grant_id)
    );

    // Ready is gated by resetn too, so nothing is offered while reset is held.
    always_comb begin
        enable       = (state == IDLE) && resetn && !global_csb;
        a_ready      = a_grant;
        b_ready      = b_grant;
        accept       = a_grant || b_grant;
        sel_in_range = int'(lat_sel) < MAX_CHIPS;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = (READ_LATENCY == 1) ? CAPT : WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = CAPT;
            CAPT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Out-of-range selects keep every chip deselected and read back as 0.
    always_comb begin
        sram_csb = '1;
        rd_word  = '0;
        if (state == ISSUE && sel_in_range) sram_csb[lat_sel] = 1'b0;
        if (sram_web && sel_in_range) rd_word = sram_dout[lat_sel*DATA_SIZE +: DATA_SIZE];
    end

    // dout is valid throughout CAPT; it is registered on the edge leaving CAPT,
    // which puts the response pulse READ_LATENCY+1 edges after the accept edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            lat_sel     <= '0;
            owner       <= REQ_A;
            wait_cnt    <= '0;
            sram_addr   <= '0;
            sram_din    <= '0;
            sram_web    <= 1'b1;
            sram_wmask  <= '0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rsp_data  <= '0;
            b_rsp_data  <= '0;
        end else begin
            state       <= state_nxt;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            wait_cnt    <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
            if (accept) begin
                owner      <= grant_id;
                lat_sel    <= b_grant ? b_sel   : a_sel;
                sram_addr  <= b_grant ? b_addr  : a_addr;
                sram_din   <= b_grant ? b_din   : a_din;
                sram_web   <= b_grant ? b_web   : a_web;
                sram_wmask <= b_grant ? b_wmask : a_wmask;
            end
            if (state == CAPT) begin
                if (owner == REQ_A) begin
                    a_rsp_valid <= 1'b1;
                    a_rsp_data  <= rd_word;
                end else begin
                    b_rsp_valid <= 1'b1;
                    b_rsp_data  <= rd_word;
                end
            end
        end
    end

endmodule
